// File: rtl/exp_lut_arbiter.sv
// Round-robin front end that shares one fixed-latency exp LUT between N_REQ requesters,
// tagging each issue with its requester and returning results through a credit-protected FIFO.
module exp_lut_arbiter #(
    parameter int WIDTH      = 32,
    parameter int N_REQ      = 4,
    parameter int LUT_LAT    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   lut_valid_in,
    output logic [WIDTH-1:0]       lut_a,
    input  logic [WIDTH-1:0]       lut_result,
    input  logic                   lut_valid_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [IDW-1:0]         rsp_id,
    output logic                   busy,
    output logic                   err_orphan
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic                 arb_en;
    logic [IDW-1:0]       rr_ptr;
    logic [CW-1:0]        inflight;
    logic [CW-1:0]        fifo_count;
    logic [CW:0]          outstanding;
    logic [CW:0]          credit_used;
    logic                 can_issue;
    logic                 found;
    logic [IDW-1:0]       grant_id;
    logic [2*N_REQ-1:0]   req_rot;
    logic                 xfer;
    logic                 retire;
    logic                 push;
    logic                 pop;
    logic [LUT_LAT:0]     tag_vld_p;
    logic [IDW-1:0]       tag_id_p [LUT_LAT+1];
    logic [WIDTH-1:0]     fifo_data [FIFO_DEPTH];
    logic [IDW-1:0]       fifo_id [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;

    // Arbitration: a pop in this cycle frees its credit for the arbiter immediately
    assign outstanding = {1'b0, inflight} + {1'b0, fifo_count};
    assign credit_used = outstanding - (CW+1)'(pop);
    assign can_issue   = arb_en && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign req_rot     = {req_valid, req_valid} >> rr_ptr;

    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req_rot[j]) begin
                found    = 1'b1;
                grant_id = IDW'((int'(rr_ptr) + j) % N_REQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found && can_issue) req_ready[grant_id] = 1'b1;
    end

    assign xfer = found && can_issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_en <= 1'b0;
            rr_ptr <= '0;
        end else begin
            arb_en <= 1'b1;
            if (xfer) rr_ptr <= IDW'((int'(grant_id) + 1) % N_REQ);
        end
    end

    // Issue stage: registered strobe and argument toward the LUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_valid_in <= 1'b0;
            lut_a        <= '0;
        end else begin
            lut_valid_in <= xfer;
            if (xfer) lut_a <= req_a[int'(grant_id)*WIDTH +: WIDTH];
        end
    end

    // Tag pipe: stage 0 tracks lut_valid_in, stage LUT_LAT lines up with lut_valid_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_p <= '0;
            for (int s = 0; s <= LUT_LAT; s++) tag_id_p[s] <= '0;
        end else begin
            tag_vld_p   <= {tag_vld_p[LUT_LAT-1:0], xfer};
            tag_id_p[0] <= grant_id;
            for (int s = 1; s <= LUT_LAT; s++) tag_id_p[s] <= tag_id_p[s-1];
        end
    end

    assign retire = tag_vld_p[LUT_LAT];
    assign push   = lut_valid_out && retire;
    assign pop    = rsp_valid && rsp_ready;

    // Retire stage: any tag/valid disagreement is flagged; the credit is released either way
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            err_orphan <= 1'b0;
        end else begin
            inflight   <= inflight + CW'(xfer) - CW'(retire);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (lut_valid_out != retire) err_orphan <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= lut_result;
            fifo_id[wr_ptr]   <= tag_id_p[LUT_LAT];
        end
    end

    // Response stage: first-word-fall-through head, forced to zero while empty
    assign rsp_valid = (fifo_count != '0);
    assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_id    = rsp_valid ? fifo_id[rd_ptr] : '0;
    assign busy      = (outstanding != '0) || lut_valid_in;

endmodule

// File: doc/exp_lut_arbiter.md
Name: exp_lut_arbiter

Overview:
- Shares one fxExpLUT-style evaluator between N_REQ requesters, e.g. per-path discount/exponent units in the LSM pipeline.
- Round-robin arbitration admits at most one argument per cycle and drives the LUT's valid/argument inputs.
- A requester tag is tracked through the fixed LUT latency.
- Results return through a credit-protected response FIFO with ready/valid backpressure. The LUT itself has no stall input.

Parameters:
- WIDTH, 32, fixed-point data width of arguments and results.
- N_REQ, 4, number of requesters (2..16).
- LUT_LAT, 1, cycles from lut_valid_in sampled to lut_valid_out asserted (1..4).
- FIFO_DEPTH, 4, response FIFO entries. Power of 2, at least LUT_LAT+1.
- IDW, $clog2(N_REQ) (minimum 1), requester ID width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester argument valid
- req_a  in  N_REQ*WIDTH  packed signed arguments; requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  N_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high
- lut_valid_in  out  1  registered issue strobe to the LUT
- lut_a  out  WIDTH  registered argument to the LUT
- lut_result  in  WIDTH  LUT result
- lut_valid_out  in  1  LUT result valid
- rsp_valid  out  1  response FIFO not empty
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  WIDTH  result at the FIFO head
- rsp_id  out  IDW  requester index at the FIFO head
- busy  out  1  any work in flight or buffered
- err_orphan  out  1  sticky: lut_valid_out arrived with no matching tag

Behaviour:
- Reset: rst_n low asynchronously clears all state, including any partially issued operation. All outputs reset to 0: req_ready, lut_valid_in, lut_a, rsp_valid, rsp_data, rsp_id, busy, err_orphan. The RR pointer resets to 0, all counters to 0. The LUT shares the same rst_n, so in-flight results are discarded.
- Credit:
  - outstanding = inflight + fifo_count.
  - inflight counts transfers that are issued or in the tag pipe and not yet pushed.
  - can_issue = (outstanding < FIFO_DEPTH). This guarantees the FIFO never overflows.
- Arbitration (combinational):
  - If can_issue, grant the first i with req_valid[i], searching from rr_ptr upward modulo N_REQ.
  - req_ready = onehot(grant), or 0 when there is no request or no credit.
  - req_ready must not depend on req_valid of the granted port combinationally beyond the arbitration itself.
- Pointer: on a transfer by requester k, rr_ptr <= (k+1) mod N_REQ. Otherwise rr_ptr holds.
- Issue:
  - A transfer in cycle T sets lut_valid_in=1 and lut_a=req_a[k] in cycle T+1.
  - With no transfer, lut_valid_in=0 and lut_a holds its last value.
- Tag pipe:
  - A LUT_LAT+1 stage shift register of {valid, id} is loaded in step with lut_valid_in.
  - The stage aligned with lut_valid_out supplies the push ID.
  - If lut_valid_out=1 but the aligned tag is invalid: set err_orphan (sticky until reset) and drop the result.
  - If the tag is valid but lut_valid_out=0: also set err_orphan and release the credit.
- Push: lut_valid_out with a valid tag writes {lut_result, id} to the FIFO at the end of that cycle.
- Latency (no backpressure, LUT_LAT=1):
  - Transfer at T → lut_valid_in at T+1 → lut_valid_out at T+2 → rsp_valid at T+3.
  - Throughput is 1 result per cycle.
- FIFO:
  - First-word-fall-through; rsp_valid = (fifo_count != 0).
  - Pop when rsp_valid && rsp_ready.
  - Simultaneous push and pop leaves the count unchanged; a push into an empty FIFO during a pop attempt is legal.
  - Pointers wrap modulo FIFO_DEPTH.
- Ordering: responses leave in issue order, which is global grant order.
- Backpressure: with rsp_ready held low, at most FIFO_DEPTH transfers are accepted, then req_ready stays 0. Each pop re-enables exactly one grant, at the earliest in the same cycle as the pop (the credit decrement is visible to the arbiter combinationally).
- busy = (outstanding != 0) || lut_valid_in.

Test Plan:
- Reset, then req_valid=4'b0001, req_a[0]=32'h0000_8000 for one cycle → lut_valid_in=1 and lut_a=32'h0000_8000 at T+1; rsp_valid=1, rsp_id=0, rsp_data=exp_lut value at T+3; busy falls after the pop.
- All four requesters valid continuously, rsp_ready=1 → grants 0,1,2,3,0,… one per cycle; rsp_id sequence 0,1,2,3,… with no gaps.
- Requesters 1 and 3 valid, rr_ptr=2 → requester 3 is granted first, then 1, then 3.
- rsp_ready=0, all requesters valid → exactly 4 transfers accepted, then req_ready=0 indefinitely. Raise rsp_ready for one cycle → one pop and exactly one new grant.
- Drive lut_valid_out=1 with the tag pipe empty → err_orphan=1 and stays 1; FIFO count unchanged.
- Assert rst_n=0 mid-stream with 3 results buffered → all outputs 0 immediately. After release, first grant goes to requester 0 and no stale responses appear.
